// File: rtl/wf_pkg.sv
// Shared types and defaults for the waveform DPBRAM player.
package wf_pkg;

  localparam int WF_ADDR_W  = 10;
  localparam int WF_DATA_W  = 16;
  localparam int READ_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    FETCH,
    EMIT
  } wf_state_t;

endpackage

// File: rtl/wf_lat_pipe.sv
// Delays the RAM enable pulse by the RAM read latency so that it lines up
// with valid read data on the RAM output.
module wf_lat_pipe #(
  parameter int LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_ce,
  output logic o_cap_en
);

  logic [LATENCY-1:0] stage;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stage <= '0;
    end else if (i_clr) begin
      stage <= '0;
    end else begin
      stage[0] <= i_ce;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign o_cap_en = stage[LATENCY-1];

endmodule

// File: rtl/wf_ram_player.sv
// Plays a stored waveform out of DPBRAM port B, one sample per sample tick,
// in single-shot or loop mode, with a saturating delivered-sample counter.
module wf_ram_player
  import wf_pkg::*;
#(
  parameter int ADDR_WIDTH  = WF_ADDR_W,
  parameter int DATA_WIDTH  = WF_DATA_W,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wf_start,
  input  logic                  i_wf_stop,
  input  logic                  i_wf_loop,
  input  logic [ADDR_WIDTH:0]   i_wf_data_num,
  input  logic                  i_sample_tick,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_ce,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,
  output logic [DATA_WIDTH-1:0] o_wf_data,
  output logic                  o_wf_valid,
  output logic                  o_wf_busy,
  output logic                  o_wf_done,
  output logic [READ_CNT_W-1:0] o_wf_read_cnt,
  output logic                  o_tick_overrun
);

  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] NUM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  wf_state_t             state, state_nxt;
  logic [ADDR_WIDTH:0]   num_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  loop_q;
  logic                  pending_q;
  logic                  cap_en;
  logic                  start_ok, last, tick_act;
  logic                  fetch_go, capture, advance;

  assign o_ram_we = 1'b0;

  assign start_ok = i_wf_start && !i_wf_stop && (state == IDLE) &&
                    (i_wf_data_num != '0) && (i_wf_data_num <= DEPTH);
  assign last     = ({1'b0, addr_q} == (num_q - NUM_ONE));
  assign tick_act = i_sample_tick && !i_wf_stop && (state != IDLE);

  wf_lat_pipe #(
    .LATENCY (RAM_LATENCY)
  ) u_lat_pipe (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (i_wf_stop),
    .i_ce     (o_ram_ce),
    .o_cap_en (cap_en)
  );

  always_comb begin
    state_nxt = state;
    fetch_go  = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = ARM;
      end
      ARM: begin
        if (i_wf_stop) begin
          state_nxt = IDLE;
        end else if (i_sample_tick || pending_q) begin
          fetch_go  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (i_wf_stop) begin
          state_nxt = IDLE;
        end else if (cap_en) begin
          capture   = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (i_wf_stop) begin
          state_nxt = IDLE;
        end else begin
          advance   = 1'b1;
          state_nxt = (last && !loop_q) ? IDLE : ARM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state          <= IDLE;
      num_q          <= '0;
      loop_q         <= 1'b0;
      addr_q         <= '0;
      pending_q      <= 1'b0;
      o_ram_addr     <= '0;
      o_ram_ce       <= 1'b0;
      o_wf_data      <= '0;
      o_wf_valid     <= 1'b0;
      o_wf_busy      <= 1'b0;
      o_wf_done      <= 1'b0;
      o_wf_read_cnt  <= '0;
      o_tick_overrun <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_wf_busy  <= (state_nxt != IDLE);
      o_ram_ce   <= fetch_go;
      o_wf_valid <= capture;
      o_wf_done  <= capture && last && !loop_q;

      if (fetch_go) o_ram_addr <= addr_q;

      if (capture) begin
        o_wf_data <= i_ram_dout;
        if (o_wf_read_cnt != '1) o_wf_read_cnt <= o_wf_read_cnt + READ_CNT_W'(1);
      end

      if (start_ok) begin
        num_q         <= i_wf_data_num;
        loop_q        <= i_wf_loop;
        addr_q        <= '0;
        o_wf_read_cnt <= '0;
      end else if (advance) begin
        addr_q <= last ? '0 : addr_q + ADDR_WIDTH'(1);
      end

      // One-deep tick buffer; a tick arriving while it is full is lost.
      if (start_ok || state_nxt == IDLE || fetch_go) begin
        pending_q <= 1'b0;
      end else if (tick_act && (state == FETCH || state == EMIT)) begin
        pending_q <= 1'b1;
      end

      if (start_ok) begin
        o_tick_overrun <= 1'b0;
      end else if (tick_act && pending_q) begin
        o_tick_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wf_ram_player.sv
// Directed bench for wf_ram_player: a per-cycle vector table on a latency-1
// instance plus hand sequences on a latency-2 instance.
module tb_wf_ram_player;

  typedef struct {
    logic        start, stop, tick, loop;
    logic [10:0] num;
    logic        ce, valid, done, busy, ovr;
    logic [9:0]  addr;
    logic [15:0] data;
    logic [31:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // latency-1 instance
  logic        rst1, start1, stop1, loop1, tick1;
  logic [10:0] num1;
  logic [9:0]  addr1;
  logic        ce1, we1, valid1, busy1, done1, ovr1;
  logic [15:0] dout1, data1;
  logic [31:0] cnt1;

  // latency-2 instance
  logic        rst2, start2, stop2, loop2, tick2;
  logic [10:0] num2;
  logic [9:0]  addr2;
  logic        ce2, we2, valid2, busy2, done2, ovr2;
  logic [15:0] dout2, data2;
  logic [31:0] cnt2;

  logic [15:0] mem [1024];
  logic [15:0] rd1, rda, rdb;

  int checks = 0;
  int errors = 0;

  vec_t        vq[$];
  logic [15:0] e_data;
  logic [31:0] e_cnt;
  logic        e_busy, e_ovr;

  wf_ram_player #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .RAM_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_wf_start(start1), .i_wf_stop(stop1),
    .i_wf_loop(loop1), .i_wf_data_num(num1), .i_sample_tick(tick1),
    .o_ram_addr(addr1), .o_ram_ce(ce1), .o_ram_we(we1), .i_ram_dout(dout1),
    .o_wf_data(data1), .o_wf_valid(valid1), .o_wf_busy(busy1), .o_wf_done(done1),
    .o_wf_read_cnt(cnt1), .o_tick_overrun(ovr1)
  );

  wf_ram_player #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .RAM_LATENCY(2)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_wf_start(start2), .i_wf_stop(stop2),
    .i_wf_loop(loop2), .i_wf_data_num(num2), .i_sample_tick(tick2),
    .o_ram_addr(addr2), .o_ram_ce(ce2), .o_ram_we(we2), .i_ram_dout(dout2),
    .o_wf_data(data2), .o_wf_valid(valid2), .o_wf_busy(busy2), .o_wf_done(done2),
    .o_wf_read_cnt(cnt2), .o_tick_overrun(ovr2)
  );

  // Behavioural DPBRAM read ports with one and two cycles of latency.
  always @(posedge clk) begin
    if (ce1) rd1 <= mem[addr1];
    if (ce2) rda <= mem[addr2];
    rdb <= rda;
  end
  assign dout1 = rd1;
  assign dout2 = rdb;

  function automatic logic [15:0] mem_val(int i);
    if (i < 4) return 16'(17 * (i + 1));
    return 16'(i * 37 + 256);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_v(logic st, logic sp, logic tk, logic lp, logic [10:0] n,
                                 logic ce, logic [9:0] ad, logic vl, logic dn);
    vec_t v;
    v.start = st;  v.stop = sp;  v.tick = tk;  v.loop = lp;  v.num = n;
    v.ce = ce;     v.addr = ad;  v.valid = vl; v.done = dn;
    v.busy = e_busy; v.ovr = e_ovr; v.data = e_data; v.cnt = e_cnt;
    vq.push_back(v);
  endfunction

  function automatic void idle(int n);
    for (int i = 0; i < n; i++) push_v(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 10'd0, 1'b0, 1'b0);
  endfunction

  function automatic void start_v(logic [10:0] n, logic lp, logic sp);
    push_v(1'b1, sp, 1'b0, lp, n, 1'b0, 10'd0, 1'b0, 1'b0);
  endfunction

  function automatic void stop_v();
    push_v(1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 10'd0, 1'b0, 1'b0);
  endfunction

  // Tick in ARM: ce/addr one cycle later, valid two cycles after that.
  function automatic void tick_sample(int a, logic [15:0] d, logic last);
    push_v(1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b1, 10'(a), 1'b0, 1'b0);
    idle(1);
    e_data = d;
    e_cnt  = e_cnt + 32'd1;
    push_v(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 10'd0, 1'b1, last);
    if (last) e_busy = 1'b0;
  endfunction

  task automatic applyStimulus(vec_t v);
    start1 = v.start;
    stop1  = v.stop;
    tick1  = v.tick;
    loop1  = v.loop;
    num1   = v.num;
    step();
  endtask

  task automatic checkOutput(vec_t v, int idx);
    check($sformatf("v%0d.ce", idx),    32'(ce1),    32'(v.ce));
    check($sformatf("v%0d.valid", idx), 32'(valid1), 32'(v.valid));
    check($sformatf("v%0d.done", idx),  32'(done1),  32'(v.done));
    check($sformatf("v%0d.busy", idx),  32'(busy1),  32'(v.busy));
    check($sformatf("v%0d.ovr", idx),   32'(ovr1),   32'(v.ovr));
    check($sformatf("v%0d.cnt", idx),   cnt1,        v.cnt);
    check($sformatf("v%0d.data", idx),  32'(data1),  32'(v.data));
    if (v.ce) check($sformatf("v%0d.addr", idx), 32'(addr1), 32'(v.addr));
  endtask

  task automatic d2_sample(int i);
    int lat;
    tick2 = 1'b1;
    step();
    tick2 = 1'b0;
    check($sformatf("d2.s%0d.ce", i),   32'(ce2),   32'd1);
    check($sformatf("d2.s%0d.addr", i), 32'(addr2), 32'(i));
    lat = 0;
    while (!valid2 && lat < 8) begin
      step();
      lat++;
    end
    check($sformatf("d2.s%0d.latency", i), 32'(lat),   32'd3);
    check($sformatf("d2.s%0d.data", i),    32'(data2), 32'(mem_val(i)));
    check($sformatf("d2.s%0d.cnt", i),     cnt2,       32'(i + 1));
    check($sformatf("d2.s%0d.done", i),    32'(done2), 32'(i == 1023));
    step();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic saw;
    for (int i = 0; i < 1024; i++) mem[i] = mem_val(i);
    rst1 = 1'b0; start1 = 1'b0; stop1 = 1'b0; loop1 = 1'b0; tick1 = 1'b0; num1 = '0;
    rst2 = 1'b0; start2 = 1'b0; stop2 = 1'b0; loop2 = 1'b0; tick2 = 1'b0; num2 = '0;
    rd1 = '0; rda = '0; rdb = '0;

    // Scenario table for the latency-1 instance.
    e_data = '0; e_cnt = '0; e_busy = 1'b0; e_ovr = 1'b0;
    e_busy = 1'b1;
    start_v(11'd4, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick_sample(k, 16'(17 * (k + 1)), k == 3);
      idle(7);
    end
    start_v(11'd0, 1'b0, 1'b0);
    start_v(11'd1025, 1'b0, 1'b0);
    start_v(11'd2, 1'b0, 1'b1);
    idle(1);
    e_busy = 1'b1; e_cnt = '0;
    start_v(11'd3, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick_sample(i % 3, 16'(17 * (i % 3 + 1)), 1'b0);
      idle(2);
      if (i == 1) start_v(11'd1, 1'b0, 1'b0);
    end
    e_busy = 1'b0;
    stop_v();
    push_v(1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 10'd0, 1'b0, 1'b0);
    idle(2);
    e_busy = 1'b1; e_cnt = '0;
    start_v(11'd4, 1'b0, 1'b0);
    tick_sample(0, 16'h0011, 1'b0);
    idle(2);
    push_v(1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b1, 10'd1, 1'b0, 1'b0);
    idle(1);
    e_busy = 1'b0;
    stop_v();
    idle(3);
    e_busy = 1'b1; e_cnt = '0;
    start_v(11'd4, 1'b0, 1'b0);
    push_v(1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b1, 10'd0, 1'b0, 1'b0);
    push_v(1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 10'd0, 1'b0, 1'b0);
    e_data = 16'h0011; e_cnt = 32'd1; e_ovr = 1'b1;
    push_v(1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 10'd0, 1'b1, 1'b0);
    idle(1);
    push_v(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b1, 10'd1, 1'b0, 1'b0);
    idle(1);
    e_data = 16'h0022; e_cnt = 32'd2;
    push_v(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 10'd0, 1'b1, 1'b0);
    idle(3);
    e_busy = 1'b0;
    stop_v();
    e_busy = 1'b1; e_ovr = 1'b0; e_cnt = '0;
    start_v(11'd2, 1'b0, 1'b0);
    tick_sample(0, 16'h0011, 1'b0);
    idle(2);
    tick_sample(1, 16'h0022, 1'b1);
    idle(2);

    repeat (3) step();
    check("rst.ce",    32'(ce1),    32'd0);
    check("rst.we",    32'(we1),    32'd0);
    check("rst.valid", 32'(valid1), 32'd0);
    check("rst.busy",  32'(busy1),  32'd0);
    check("rst.done",  32'(done1),  32'd0);
    check("rst.data",  32'(data1),  32'd0);
    check("rst.cnt",   cnt1,        32'd0);
    check("rst.ovr",   32'(ovr1),   32'd0);
    check("rst.addr",  32'(addr1),  32'd0);
    rst1 = 1'b1;
    rst2 = 1'b1;
    step();

    foreach (vq[i]) begin
      applyStimulus(vq[i]);
      checkOutput(vq[i], i);
    end

    // Latency-2 instance: reset in the middle of a fetch.
    start2 = 1'b1; num2 = 11'd1024; loop2 = 1'b0;
    step();
    start2 = 1'b0;
    check("d2.busy_after_start", 32'(busy2), 32'd1);
    d2_sample(0);
    tick2 = 1'b1;
    step();
    tick2 = 1'b0;
    step();
    #2;
    rst2 = 1'b0;
    #1;
    check("d2.rst.ce",    32'(ce2),    32'd0);
    check("d2.rst.valid", 32'(valid2), 32'd0);
    check("d2.rst.busy",  32'(busy2),  32'd0);
    check("d2.rst.done",  32'(done2),  32'd0);
    check("d2.rst.data",  32'(data2),  32'd0);
    check("d2.rst.cnt",   cnt2,        32'd0);
    check("d2.rst.ovr",   32'(ovr2),   32'd0);
    check("d2.rst.addr",  32'(addr2),  32'd0);
    step();
    rst2 = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid2 || busy2 || ce2 || done2) saw = 1'b1;
    end
    check("d2.quiet_after_reset", 32'(saw), 32'd0);

    // Full-depth single-shot run.
    start2 = 1'b1; num2 = 11'd1024;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 1024; i++) d2_sample(i);
    check("d2.busy_after_done", 32'(busy2), 32'd0);
    check("d2.final_cnt",       cnt2,       32'd1024);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
